alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 82 ++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester front end for a shared combinational ALU.
// Round-robin arbitration by default; define ALU_ARBITER_FIXED_PRIO_EN for fixed priority (requester 0 wins).
module alu_arbiter #(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic              req1_valid,
  output logic              req0_ready,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [SEL_W-1:0]  req0_sel,
  input  logic [SEL_W-1:0]  req1_sel,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [SEL_W-1:0]  alu_sel,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_carry,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_carry
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  state_t state, state_nx;
  logic g0, g1, acc0, acc1;
`ifdef ALU_ARBITER_FIXED_PRIO_EN
  assign g0 = req0_valid;
  assign g1 = req1_valid & ~req0_valid;
`else
  logic last_grant;
  assign g0 = req0_valid & (~req1_valid | last_grant);
  assign g1 = req1_valid & (~req0_valid | ~last_grant);
  // remember who won the last accepted request; 1 after reset so requester 0 wins the first tie
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_grant <= 1'b1;
    else if (acc0 | acc1) last_grant <= acc1;
`endif
  assign acc0 = (state == IDLE) & g0;
  assign acc1 = (state == IDLE) & g1;
  assign req0_ready = rst_n & acc0;
  assign req1_ready = rst_n & acc1;
  assign rsp_valid  = (state == RESP);
  // next state: accept -> one ISSUE cycle -> RESP until the response is taken
  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE)  ? ((acc0 | acc1) ? ISSUE : IDLE) :
               (state == ISSUE) ? RESP :
               (rsp_ready ? IDLE : RESP);
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // latch the granted operands on accept, capture the ALU result at the end of ISSUE
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      rsp_carry <= 1'b0;
    end else begin
      if (acc0 | acc1) begin
        alu_a   <= acc1 ? req1_a : req0_a;
        alu_b   <= acc1 ? req1_b : req0_b;
        alu_sel <= acc1 ? req1_sel : req0_sel;
        rsp_id  <= acc1;
      end
      if (state == ISSUE) begin
        rsp_data  <= alu_out;
        rsp_carry <= alu_carry;
      end
    end
endmodule
